writeback_queue: RTL



---
 rtl/rv_pkg.sv | 19 +
 rtl/load_align.sv | 23 ++
 rtl/writeback_queue.sv | 91 +++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared writeback kinds, load funct3 codes and queue entry layout
package rv_pkg;
  localparam int REG_AW = 5;
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LOAD = 2'd2,
    WB_LINK = 2'd3
  } wb_kind_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [31:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/load_align.sv
// load_align: extracts and extends the addressed byte/halfword of a load word
module load_align
  import rv_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  output logic [31:0] o_value
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  // halfword selection ignores offset[0]; unknown funct3 codes pass the word through
  always_comb begin
    w_byte  = i_word[{i_offset, 3'b000} +: 8];
    w_half  = i_offset[1] ? i_word[31:16] : i_word[15:0];
    o_value = i_funct3 == F3_LB  ? {{24{w_byte[7]}}, w_byte}
            : i_funct3 == F3_LBU ? {24'h0, w_byte}
            : i_funct3 == F3_LH  ? {{16{w_half[15]}}, w_half}
            : i_funct3 == F3_LHU ? {16'h0, w_half}
            : i_funct3 == F3_LW  ? i_word
            : i_word;
  end
endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: in-order result buffer draining into the register file write port
module writeback_queue
  import rv_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [1:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic [1:0]        in_byte_offset,
  input  logic [31:0]       in_alu_result,
  input  logic [31:0]       in_load_word,
  input  logic [31:0]       in_pc_plus4,
  input  logic              read_request,
  input  logic [REG_AW-1:0] read_address1,
  input  logic [REG_AW-1:0] read_address2,
  output logic              read_granted,
  output logic              hazard1,
  output logic              hazard2,
  output logic [REG_AW-1:0] write_address,
  output logic [31:0]       write_data,
  output logic              write_enable,
  output logic              idle
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  wb_entry_t         r_q [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [SW-1:0]     r_starve;
  logic              w_empty;
  logic              w_starve;
  logic              w_push;
  logic [31:0]       w_load;
  logic [31:0]       w_value;
  load_align u_align (
    .i_funct3 (in_funct3),
    .i_offset (in_byte_offset),
    .i_word   (in_load_word),
    .o_value  (w_load)
  );
  // accept/drain control; the write port only sees the registered head, never the input
  always_comb begin
    w_empty       = r_count == '0;
    w_starve      = r_starve == SW'(STARVE_LIMIT);
    in_ready      = r_count != CW'(DEPTH);
    w_push        = in_valid && in_ready && in_kind != WB_NONE && in_rd != '0;
    w_value       = in_kind == WB_ALU ? in_alu_result : in_kind == WB_LINK ? in_pc_plus4 : w_load;
    write_enable  = !w_empty && (!read_request || w_starve);
    write_address = w_empty ? '0 : r_q[r_head].rd;
    write_data    = w_empty ? '0 : r_q[r_head].data;
    read_granted  = read_request && !write_enable;
    idle          = w_empty;
  end
  // an entry is live when its distance from the head is below the occupancy
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(i) - r_head} < r_count) begin
        hazard1 = hazard1 || (read_address1 != '0 && r_q[i].rd == read_address1);
        hazard2 = hazard2 || (read_address2 != '0 && r_q[i].rd == read_address2);
      end
    end
  end
  // entry storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_tail] <= '{rd: in_rd, data: w_value};
  end
  // pointers, occupancy and the deferral counter; reset drops anything queued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (write_enable) r_head <= r_head + 1'b1;
      r_count  <= r_count + CW'(w_push) - CW'(write_enable);
      r_starve <= (w_empty || write_enable) ? '0 : r_starve + 1'b1;
    end
  end
endmodule
